mem_link_arbiter: RTL and testbench
===================================

Name: mem_link_arbiter

Overview:
Shares the single external memory command/beat port between the four datapath clients: 0=uart, 1=conv, 2=pool, 3=fc.
- The system state controller's per-client link enables qualify which requesters may compete.
- Arbitration is round-robin, one burst per grant; the grant holds until the burst's final beat.
- Provides per-client done pulses, a busy flag and a beat watchdog.

Parameters:
NREQ, 4, number of requesters (index 0..NREQ-1)
AW, 28, memory address width
LW, 8, burst length field width; field encodes beats-1, so 1..2^LW beats
TMO, 255, max idle cycles between beats inside a burst before timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
link_en  in  NREQ  per-client enable from sys_state_ctrl (link_read|link_write)
req  in  NREQ  level request, held until gnt seen
req_we  in  NREQ  1=write burst, 0=read burst
req_addr  in  NREQ*AW  start address, client i at [i*AW +: AW]
req_len  in  NREQ*LW  beats-1, client i at [i*LW +: LW]
gnt  out  NREQ  one-hot grant, registered
req_done  out  NREQ  one-cycle pulse on the granted client at burst end
cur_id  out  2  index of current/last granted client
busy  out  1  high while not IDLE
err_tmo  out  1  sticky watchdog flag
mem_cmd_valid  out  1  command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_we  out  1  captured req_we of winner
mem_cmd_addr  out  AW  captured address
mem_cmd_len  out  LW  captured length
mem_beat  in  1  one data beat transferred this cycle

Behaviour:
- Reset (rst_n low at a clock edge):
  - State=IDLE, rr_ptr=0, cur_id=0, beat_cnt=0, wdog=0.
  - gnt=0, req_done=0, busy=0, err_tmo=0.
  - mem_cmd_valid=0, mem_cmd_we=0, mem_cmd_addr=0, mem_cmd_len=0.
  - Reset mid-burst aborts silently; no req_done is issued.
- Eligible requesters: elig = req & link_en.
- States: IDLE, CMD, BURST.
- IDLE:
  - If elig!=0, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Next edge: gnt=onehot(winner), cur_id=winner, capture the winner's we/addr/len into mem_cmd_*, mem_cmd_valid=1, state=CMD.
  - Latency: request to gnt/mem_cmd_valid is 1 cycle.
- CMD:
  - mem_cmd_valid held, command fields stable, until mem_cmd_ready=1 at an edge.
  - Then mem_cmd_valid=0, beat_cnt=0, wdog=0, state=BURST.
  - A mem_beat in the same cycle as mem_cmd_ready is counted.
- BURST:
  - Each mem_beat: beat_cnt+1 and wdog=0; otherwise wdog+1.
  - Burst ends on the mem_beat where beat_cnt==mem_cmd_len. At that edge: gnt=0, req_done[cur_id]=1 for one cycle, rr_ptr=(cur_id+1) mod NREQ, state=IDLE.
  - Watchdog: when wdog reaches TMO with no beat, err_tmo=1 (sticky until reset), gnt=0, no req_done, rr_ptr advances, state=IDLE.
- IDLE after a done is a mandatory dead cycle: no back-to-back grant in the same cycle as req_done.
- Boundary rules:
  - link_en or req dropped during CMD/BURST does not abort; the burst completes.
  - Inputs from non-granted clients are ignored while busy.
  - mem_beat while in IDLE or CMD-without-ready is ignored.
  - len=0 gives a single-beat burst; len=2^LW-1 gives 256 beats with no counter overflow (beat_cnt is LW bits and compares before incrementing).
  - req_done rises only together with the IDLE transition.
- busy = (state!=IDLE), registered.

Decomposition:
- Package aisys_pkg holds:
  - state typedef {IDLE, CMD, BURST}
  - client index constants UART_ID=0, CONV_ID=1, POOL_ID=2, FC_ID=3
  - widths AW=28 and LW=8 as defaults
- Sub-module rr_pick: combinational round-robin first-one search; inputs elig and rr_ptr, outputs winner index and valid. Reused by later arbiters.

Test Plan:
- Single request: link_en=4'b0010, req[1]=1, addr=28'h0001000, len=3, cmd_ready immediate, 4 beats -> gnt=0010 one cycle after req, mem_cmd_addr=0001000, req_done[1] on the 4th beat edge, rr_ptr=2.
- Round-robin: req=1111, link_en=1111, len=0, beat every cycle -> grants ordered 0,1,2,3,0, with one dead IDLE cycle between grants.
- Masking: req=0101, link_en=0100 -> only client 2 granted; client 0 never granted until link_en[0]=1.
- Backpressure: mem_cmd_ready low 5 cycles -> mem_cmd_valid and fields stable for 5 cycles; beats before ready ignored.
- Timeout: TMO=255, len=7, beats stop after 2 -> err_tmo=1 and gnt=0 exactly 255 cycles after the last beat, no req_done; next request still served.
- Reset mid-burst: rst_n low during BURST -> next edge all outputs at reset values, no req_done, rr_ptr=0.

Source files
------------

// File: rtl/aisys_pkg.sv
// Shared types and constants for the AI-system memory-side blocks.
package aisys_pkg;

  typedef enum logic [1:0] {IDLE, CMD, BURST} arb_state_e;

  localparam int UART_ID = 0;
  localparam int CONV_ID = 1;
  localparam int POOL_ID = 2;
  localparam int FC_ID   = 3;

  localparam int DEF_AW = 28;
  localparam int DEF_LW = 8;

endpackage

// File: rtl/mem_link_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible requester at or after rr_ptr_i.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            vld_o
);

  int idx;

  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_i) + i) % NREQ;
      if (!vld_o && elig_i[idx]) begin
        win_o = IW'(idx);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_link_arbiter.sv
// Round-robin arbiter sharing one memory command/beat port among the datapath
// clients; one burst per grant, with a beat watchdog.
module mem_link_arbiter
  import aisys_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEF_AW,
  parameter int LW   = DEF_LW,
  parameter int TMO  = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                link_en,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ*AW-1:0]             req_addr,
  input  logic [NREQ*LW-1:0]             req_len,
  output logic [NREQ-1:0]                gnt,
  output logic [NREQ-1:0]                req_done,
  output logic [$clog2(NREQ)-1:0]        cur_id,
  output logic                           busy,
  output logic                           err_tmo,
  output logic                           mem_cmd_valid,
  input  logic                           mem_cmd_ready,
  output logic                           mem_cmd_we,
  output logic [AW-1:0]                  mem_cmd_addr,
  output logic [LW-1:0]                  mem_cmd_len,
  input  logic                           mem_beat
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TMO + 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d, cur_id_q, cur_id_d;
  logic [LW-1:0]   beat_cnt_q, beat_cnt_d, len_q, len_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            err_q, err_d, vld_q, vld_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;

  logic [NREQ-1:0] elig;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic            burst_end, tmo_hit;

  assign elig = req & link_en;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (win),
    .vld_o    (win_vld)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    beat_cnt_d = beat_cnt_q;
    wdog_d     = wdog_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = err_q;
    vld_d      = vld_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_end  = 1'b0;
    tmo_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          cur_id_d   = win;
          vld_d      = 1'b1;
          we_d       = req_we[win];
          addr_d     = req_addr[int'(win)*AW +: AW];
          len_d      = req_len[int'(win)*LW +: LW];
          state_d    = CMD;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          vld_d      = 1'b0;
          beat_cnt_d = '0;
          wdog_d     = '0;
          state_d    = BURST;
          // A beat accepted alongside the command counts as the first beat.
          if (mem_beat) begin
            if (len_q == '0) burst_end = 1'b1;
            else             beat_cnt_d = LW'(1);
          end
        end
      end
      BURST: begin
        if (mem_beat) begin
          wdog_d = '0;
          if (beat_cnt_q == len_q) burst_end = 1'b1;
          else                     beat_cnt_d = beat_cnt_q + LW'(1);
        end else if (wdog_q == WW'(TMO - 1)) begin
          tmo_hit = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (burst_end || tmo_hit) begin
      gnt_d    = '0;
      state_d  = IDLE;
      rr_ptr_d = (cur_id_q == IW'(NREQ - 1)) ? '0 : cur_id_q + IW'(1);
      if (burst_end) done_d = gnt_q;
      if (tmo_hit)   err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      beat_cnt_q <= '0;
      wdog_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      beat_cnt_q <= beat_cnt_d;
      wdog_q     <= wdog_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

  assign gnt           = gnt_q;
  assign req_done      = done_q;
  assign cur_id        = cur_id_q;
  assign busy          = (state_q != IDLE);
  assign err_tmo       = err_q;
  assign mem_cmd_valid = vld_q;
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_len   = len_q;

endmodule

// File: tb/tb_mem_link_arbiter.sv
// Directed bench for mem_link_arbiter; inputs driven and outputs checked on negedge.
module tb_mem_link_arbiter;
  localparam int NREQ = 4, AW = 28, LW = 8, TMO = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   link_en, req, req_we, gnt, req_done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [1:0]        cur_id;
  logic              busy, err_tmo, mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_beat;
  logic [AW-1:0]     mem_cmd_addr;
  logic [LW-1:0]     mem_cmd_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_link_arbiter #(.NREQ(NREQ), .AW(AW), .LW(LW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .link_en(link_en), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .gnt(gnt), .req_done(req_done),
    .cur_id(cur_id), .busy(busy), .err_tmo(err_tmo), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len(mem_cmd_len), .mem_beat(mem_beat)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 0);
    chk({tag, "_done"}, 32'(req_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"},  32'(err_tmo), 0);
    chk({tag, "_vld"},  32'(mem_cmd_valid), 0);
    chk({tag, "_we"},   32'(mem_cmd_we), 0);
    chk({tag, "_addr"}, 32'(mem_cmd_addr), 0);
    chk({tag, "_len"},  32'(mem_cmd_len), 0);
    chk({tag, "_id"},   32'(cur_id), 0);
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; link_en = '0; req = '0; req_we = '0; req_addr = '0; req_len = '0;
    mem_cmd_ready = 1'b0; mem_beat = 1'b0;
    tick(); tick();
    chk_reset("rst");

    // single request, client 1, 4 beats
    rst_n = 1'b1;
    link_en = 4'b0010; req = 4'b0010; req_we = 4'b0010;
    req_addr[1*AW +: AW] = 28'h0001000; req_len[1*LW +: LW] = 8'd3;
    mem_cmd_ready = 1'b1;
    tick();
    chk("s_gnt", 32'(gnt), 4'b0010);
    chk("s_vld", 32'(mem_cmd_valid), 1);
    chk("s_addr", 32'(mem_cmd_addr), 28'h0001000);
    chk("s_len", 32'(mem_cmd_len), 3);
    chk("s_we", 32'(mem_cmd_we), 1);
    chk("s_id", 32'(cur_id), 1);
    chk("s_busy", 32'(busy), 1);
    req = '0;
    tick();
    chk("s_vld_drop", 32'(mem_cmd_valid), 0);
    mem_beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_mid_done", 32'(req_done), 0);
      chk("s_mid_gnt", 32'(gnt), 4'b0010);
    end
    tick();
    chk("s_done", 32'(req_done), 4'b0010);
    chk("s_end_gnt", 32'(gnt), 0);
    chk("s_end_busy", 32'(busy), 0);

    // rr_ptr is now 2: of {0,1,3} client 3 wins; len0 beat with ready ends at once
    link_en = 4'b1111; req = 4'b1011; req_len[3*LW +: LW] = 8'd0;
    tick();
    chk("p_done_clear", 32'(req_done), 0);
    chk("p_gnt", 32'(gnt), 4'b1000);
    chk("p_id", 32'(cur_id), 3);
    tick();
    chk("p_done", 32'(req_done), 4'b1000);
    chk("p_gnt_off", 32'(gnt), 0);

    // round robin, all clients, single-beat bursts, beat every cycle
    req = 4'b1111; req_len = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
      chk("rr_nodone", 32'(req_done), 0);
      tick();
      chk("rr_done", 32'(req_done), 32'(rr_exp[k]));
      chk("rr_dead", 32'(gnt), 0);
    end

    // masking: client 0 requests but is not link-enabled
    req = 4'b0101; link_en = 4'b0100; mem_beat = 1'b0; mem_cmd_ready = 1'b0;
    tick();
    chk("m_gnt1", 32'(gnt), 4'b0100);
    mem_cmd_ready = 1'b1; mem_beat = 1'b1;
    tick();
    chk("m_done1", 32'(req_done), 4'b0100);
    tick();
    chk("m_gnt2", 32'(gnt), 4'b0100);
    tick();
    chk("m_done2", 32'(req_done), 4'b0100);
    link_en = 4'b0101;
    tick();
    chk("m_gnt0", 32'(gnt), 4'b0001);
    tick();
    chk("m_done0", 32'(req_done), 4'b0001);

    // backpressure: ready low 5 cycles, beats ignored until accepted
    req = 4'b0010; link_en = 4'b1111; req_we = 4'b0010;
    req_addr[1*AW +: AW] = 28'hABCDE12; req_len[1*LW +: LW] = 8'd1;
    mem_cmd_ready = 1'b0; mem_beat = 1'b1;
    tick();
    chk("b_gnt", 32'(gnt), 4'b0010);
    req = '0; req_addr[1*AW +: AW] = 28'h0; req_len[1*LW +: LW] = 8'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_vld", 32'(mem_cmd_valid), 1);
      chk("b_addr", 32'(mem_cmd_addr), 28'hABCDE12);
      chk("b_len", 32'(mem_cmd_len), 1);
      chk("b_done", 32'(req_done), 0);
    end
    mem_cmd_ready = 1'b1; mem_beat = 1'b0;
    tick();
    chk("b_vld_off", 32'(mem_cmd_valid), 0);
    mem_beat = 1'b1;
    tick();
    chk("b_beat1", 32'(req_done), 0);
    tick();
    chk("b_done2", 32'(req_done), 4'b0010);

    // watchdog: len 7, two beats then silence
    req = 4'b0100; req_len[2*LW +: LW] = 8'd7; mem_beat = 1'b0;
    tick();
    chk("t_gnt", 32'(gnt), 4'b0100);
    req = '0;
    tick();
    mem_beat = 1'b1;
    tick(); tick();
    mem_beat = 1'b0;
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("t_err_early", 32'(err_tmo), 0);
    chk("t_gnt_held", 32'(gnt), 4'b0100);
    tick();
    chk("t_err", 32'(err_tmo), 1);
    chk("t_gnt_off", 32'(gnt), 0);
    chk("t_nodone", 32'(req_done), 0);
    chk("t_busy", 32'(busy), 0);
    req = 4'b0001; req_len[0*LW +: LW] = 8'd0;
    tick();
    chk("t_next_gnt", 32'(gnt), 4'b0001);
    req = '0; mem_beat = 1'b1;
    tick();
    chk("t_next_done", 32'(req_done), 4'b0001);
    chk("t_sticky", 32'(err_tmo), 1);

    // reset mid-burst
    mem_beat = 1'b0; req = 4'b0010; req_len[1*LW +: LW] = 8'd5;
    tick();
    chk("r_gnt", 32'(gnt), 4'b0010);
    tick();
    mem_beat = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk_reset("r_mid");
    rst_n = 1'b1; mem_beat = 1'b0; req = 4'b1111;
    tick();
    chk("r_ptr0", 32'(gnt), 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
